// File: rtl/error_inject_seq.sv
// Streaming bit-error injector: flips a burst of codeword bits at a fixed or
// auto-sweeping position behind a one-deep registered valid/ready slice.
module error_inject_seq #(
  parameter int DATA_W = 80,
  parameter int POS_W  = $clog2(DATA_W),
  parameter int LEN_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [POS_W-1:0]  cfg_pos,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              load,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_mask,
  output logic              sweep_wrap,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [1:0] MODE_FIXED = 2'd1;
  localparam logic [1:0] MODE_SWEEP = 2'd2;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] out_mask_q, out_mask_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              sweep_wrap_q, sweep_wrap_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              accept;
  logic              mask_en;
  logic [POS_W-1:0]  start_pos;
  logic [POS_W:0]    end_pos;
  logic [DATA_W-1:0] mask;

  // Handshake: a word transfers on any edge where valid && ready; the slice
  // accepts whenever it is empty or its held word leaves on the same edge.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Burst end uses one extra bit so p+len never wraps; bits past the MSB drop.
  always_comb begin
    mask_en   = 1'b0;
    start_pos = '0;
    case (mode)
      MODE_FIXED: begin mask_en = 1'b1; start_pos = cfg_pos; end
      MODE_SWEEP: begin mask_en = 1'b1; start_pos = pos_q;   end
      default:    begin mask_en = 1'b0; start_pos = '0;      end
    endcase
    end_pos = {1'b0, start_pos} + (POS_W+1)'(cfg_len);
    mask    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = mask_en && (i >= int'(start_pos)) && (i < int'(end_pos));
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_mask_d   = out_mask_q;
    pos_d        = pos_q;
    sweep_wrap_d = 1'b0;
    err_cnt_d    = err_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ mask;
      out_mask_d  = mask;
      if ((|mask) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A load overrides the sweep step, so it also suppresses the wrap pulse.
    if (load) begin
      pos_d = cfg_pos;
    end else if (accept && (mode == MODE_SWEEP)) begin
      if (pos_q >= POS_W'(DATA_W-1)) begin
        pos_d        = '0;
        sweep_wrap_d = 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_mask_q   <= '0;
      pos_q        <= '0;
      sweep_wrap_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_mask_q   <= out_mask_d;
      pos_q        <= pos_d;
      sweep_wrap_q <= sweep_wrap_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_mask   = out_mask_q;
  assign sweep_wrap = sweep_wrap_q;
  assign err_cnt    = err_cnt_q;

endmodule
